// File: rtl/pipe_ctrl_pkg.sv
// Shared RISC-V constants for the pipeline controller, hazard unit and decoder,
// plus the saturating-increment helper used by the performance counters.
package pipe_ctrl_pkg;

  localparam logic [31:0] NOP_INST         = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
  localparam logic [31:0] CNT_MAX          = 32'hFFFF_FFFF;

  // Major opcode field, inst[6:0]
  localparam logic [6:0] OPC_LOAD   = 7'b000_0011;
  localparam logic [6:0] OPC_OP_IMM = 7'b001_0011;
  localparam logic [6:0] OPC_AUIPC  = 7'b001_0111;
  localparam logic [6:0] OPC_STORE  = 7'b010_0011;
  localparam logic [6:0] OPC_OP     = 7'b011_0011;
  localparam logic [6:0] OPC_LUI    = 7'b011_0111;
  localparam logic [6:0] OPC_BRANCH = 7'b110_0011;
  localparam logic [6:0] OPC_JALR   = 7'b110_0111;
  localparam logic [6:0] OPC_JAL    = 7'b110_1111;

  function automatic logic [31:0] sat_inc(input logic [31:0] value, input logic en);
    return (en && (value != CNT_MAX)) ? value + 32'd1 : value;
  endfunction

endpackage

// File: rtl/pipe_ctrl_stage.sv
// Pipeline stage register carrying an instruction and its PC.
// Priority: reset > bubble (load NOP, pc 0) > hold > load.
module pipe_stage_reg
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] BUBBLE_INST = NOP_INST
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_bubble,
  input  logic        i_hold,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_pc,
  output logic [31:0] o_inst,
  output logic [31:0] o_pc
);

  logic [31:0] r_inst;
  logic [31:0] r_pc;

  always_ff @(posedge i_clk) begin
    if (i_rst || i_bubble) begin
      r_inst <= BUBBLE_INST;
      r_pc   <= 32'h0;
    end else if (!i_hold) begin
      r_inst <= i_inst;
      r_pc   <= i_pc;
    end
  end

  assign o_inst = r_inst;
  assign o_pc   = r_pc;

endmodule

// File: rtl/pipe_ctrl.sv
// Five-stage pipeline controller: fetch PC, per-stage instruction registers,
// stall/flush handling and saturating performance counters.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter logic [31:0] RESET_PC = RESET_PC_DEFAULT,
  parameter logic [31:0] NOP      = NOP_INST,
  parameter logic [31:0] CNT_INIT = 32'h0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic [31:0] i_imem_rdata,
  input  logic        i_stall,
  input  logic        i_flush,
  input  logic [31:0] i_target,
  output logic [31:0] o_pc,
  output logic [31:0] o_instF,
  output logic [31:0] o_instD,
  output logic [31:0] o_instE,
  output logic [31:0] o_instM,
  output logic [31:0] o_instW,
  output logic [31:0] o_pcD,
  output logic [31:0] o_pcE,
  output logic [31:0] o_stall_cnt,
  output logic [31:0] o_flush_cnt,
  output logic [31:0] o_retire_cnt
);

  logic [31:0] r_pc;
  logic        r_fetch_valid;
  logic [31:0] r_instM;
  logic [31:0] r_instW;
  logic [31:0] r_stall_cnt;
  logic [31:0] r_flush_cnt;
  logic [31:0] r_retire_cnt;

  logic        w_stall_eff;
  logic [31:0] w_instF;

  assign w_stall_eff = i_stall && !i_flush;
  assign w_instF     = r_fetch_valid ? i_imem_rdata : NOP;

  // A NOP fetch slot keeps pc in place so the word at that address is fetched next cycle, not skipped.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pc          <= RESET_PC;
      r_fetch_valid <= 1'b0;
    end else if (i_flush) begin
      r_pc          <= i_target;
      r_fetch_valid <= 1'b0;
    end else begin
      r_fetch_valid <= 1'b1;
      if (!i_stall && r_fetch_valid)
        r_pc <= r_pc + 32'd4;
    end
  end

  pipe_stage_reg #(.BUBBLE_INST(NOP)) u_stage_d (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_bubble (i_flush),
    .i_hold   (w_stall_eff),
    .i_inst   (w_instF),
    .i_pc     (r_pc),
    .o_inst   (o_instD),
    .o_pc     (o_pcD)
  );

  pipe_stage_reg #(.BUBBLE_INST(NOP)) u_stage_e (
    .i_clk    (i_clk),
    .i_rst    (i_rst),
    .i_bubble (i_flush || i_stall),
    .i_hold   (1'b0),
    .i_inst   (o_instD),
    .i_pc     (o_pcD),
    .o_inst   (o_instE),
    .o_pc     (o_pcE)
  );

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_instM <= NOP;
      r_instW <= NOP;
    end else begin
      r_instM <= o_instE;
      r_instW <= r_instM;
    end
  end

  // A stall that coincides with a flush is not counted: the flush wins.
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_stall_cnt  <= CNT_INIT;
      r_flush_cnt  <= CNT_INIT;
      r_retire_cnt <= CNT_INIT;
    end else begin
      r_stall_cnt  <= sat_inc(r_stall_cnt, w_stall_eff);
      r_flush_cnt  <= sat_inc(r_flush_cnt, i_flush);
      r_retire_cnt <= sat_inc(r_retire_cnt, r_instW != NOP);
    end
  end

  assign o_pc         = r_pc;
  assign o_instF      = w_instF;
  assign o_instM      = r_instM;
  assign o_instW      = r_instW;
  assign o_stall_cnt  = r_stall_cnt;
  assign o_flush_cnt  = r_flush_cnt;
  assign o_retire_cnt = r_retire_cnt;

endmodule

// File: tb/tb_pipe_ctrl.sv
// Self-checking bench for pipe_ctrl: reset, straight-line flow, stalls, flushes,
// reset priority, PC wrap and counter saturation (second instance preset near max).
module tb_pipe_ctrl;

  localparam logic [31:0] NOPW = 32'h0000_0013;
  localparam logic [31:0] MAXW = 32'hFFFF_FFFF;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic        flush;
  logic [31:0] target;

  logic [31:0] imemRdata, pc, instF, instD, instE, instM, instW, pcD, pcE;
  logic [31:0] stallCnt, flushCnt, retireCnt;
  logic [31:0] satImem, satPc, satInstF, satInstD, satInstE, satInstM, satInstW, satPcD, satPcE;
  logic [31:0] satStallCnt, satFlushCnt, satRetireCnt;

  int          errors = 0;
  int          checks = 0;
  logic [31:0] expQ[$];
  logic [31:0] expW;

  always #5 clk = ~clk;

  // Instruction memory image: low 7 bits are 0x33, so no word ever equals the NOP.
  function automatic logic [31:0] memWord(input logic [31:0] a);
    return {a[24:0], 7'h33};
  endfunction

  assign imemRdata = memWord(pc);
  assign satImem   = memWord(satPc);

  pipe_ctrl dut (
    .i_clk(clk), .i_rst(rst), .i_imem_rdata(imemRdata), .i_stall(stall), .i_flush(flush),
    .i_target(target), .o_pc(pc), .o_instF(instF), .o_instD(instD), .o_instE(instE),
    .o_instM(instM), .o_instW(instW), .o_pcD(pcD), .o_pcE(pcE), .o_stall_cnt(stallCnt),
    .o_flush_cnt(flushCnt), .o_retire_cnt(retireCnt)
  );

  pipe_ctrl #(.CNT_INIT(32'hFFFF_FFFE)) dutSat (
    .i_clk(clk), .i_rst(rst), .i_imem_rdata(satImem), .i_stall(stall), .i_flush(flush),
    .i_target(target), .o_pc(satPc), .o_instF(satInstF), .o_instD(satInstD), .o_instE(satInstE),
    .o_instM(satInstM), .o_instW(satInstW), .o_pcD(satPcD), .o_pcE(satPcE),
    .o_stall_cnt(satStallCnt), .o_flush_cnt(satFlushCnt), .o_retire_cnt(satRetireCnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst = 1'b1; stall = 1'b0; flush = 1'b0; target = 32'h0;
    tick();
    tick();
    rst = 1'b0;
  endtask

  task automatic checkResetState(input string tag);
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL %s_pc: got %h expected %h", tag, pc, 32'h0); end
    checks++; if ({instD, instE, instM, instW} !== {4{NOPW}}) begin errors++;
      $display("[TB] FAIL %s_insts: got %h %h %h %h expected all %h", tag, instD, instE, instM, instW, NOPW); end
    checks++; if ({pcD, pcE} !== 64'h0) begin errors++; $display("[TB] FAIL %s_stage_pcs: got %h %h expected 0", tag, pcD, pcE); end
    checks++; if ({stallCnt, flushCnt, retireCnt} !== 96'h0) begin errors++;
      $display("[TB] FAIL %s_counters: got %h %h %h expected 0", tag, stallCnt, flushCnt, retireCnt); end
    checks++; if (instF !== NOPW) begin errors++; $display("[TB] FAIL %s_instF: got %h expected %h", tag, instF, NOPW); end
  endtask

  task automatic test_reset();
    doReset();
    checkResetState("reset");
    tick();
    checks++; if (pc !== 32'h0) begin errors++; $display("[TB] FAIL reset_pc_hold: got %h expected %h", pc, 32'h0); end
    checks++; if (instF !== memWord(32'h0)) begin errors++; $display("[TB] FAIL reset_first_fetch: got %h expected %h", instF, memWord(32'h0)); end
    tick();
    checks++; if (pc !== 32'h4) begin errors++; $display("[TB] FAIL reset_pc_advance: got %h expected %h", pc, 32'h4); end
  endtask

  task automatic test_straight_line();
    doReset();
    expQ.delete();
    for (int k = 0; k < 4; k++) expQ.push_back(memWord(32'(k * 4)));
    for (int k = 1; k <= 9; k++) begin
      tick();
      if (k == 2) begin
        checks++; if ({instD, pcD} !== {memWord(32'h0), 32'h0}) begin errors++;
          $display("[TB] FAIL straight_D: got %h/%h expected %h/%h", instD, pcD, memWord(32'h0), 32'h0); end
      end
      if (k == 4) begin
        checks++; if (instW !== NOPW) begin errors++; $display("[TB] FAIL straight_W_early: got %h expected %h", instW, NOPW); end
      end
      if (k >= 5 && expQ.size() > 0) begin
        expW = expQ.pop_front();
        checks++; if (instW !== expW) begin errors++; $display("[TB] FAIL straight_W_c%0d: got %h expected %h", k, instW, expW); end
      end
      if (k == 6) begin
        checks++; if (retireCnt !== 32'd1) begin errors++; $display("[TB] FAIL straight_retire: got %0d expected 1", retireCnt); end
      end
    end
    checks++; if (expQ.size() != 0) begin errors++; $display("[TB] FAIL straight_drain: got %0d left expected 0", expQ.size()); end
  endtask

  task automatic test_stall();
    doReset();
    tick(); tick(); tick();
    stall = 1'b1;
    expQ.delete();
    expQ.push_back(memWord(32'h0));
    for (int k = 0; k < 3; k++) expQ.push_back(NOPW);
    expQ.push_back(memWord(32'h4));
    for (int k = 4; k <= 9; k++) begin
      tick();
      if (k == 4) begin
        checks++; if ({instD, instE, pcE, pc} !== {memWord(32'h4), NOPW, 32'h0, 32'h8}) begin errors++;
          $display("[TB] FAIL stall_first: got D=%h E=%h pcE=%h pc=%h", instD, instE, pcE, pc); end
        checks++; if ({instM, stallCnt} !== {memWord(32'h0), 32'd1}) begin errors++;
          $display("[TB] FAIL stall_first_cnt: got M=%h cnt=%0d expected M=%h cnt=1", instM, stallCnt, memWord(32'h0)); end
      end
      if (k == 6) begin
        checks++; if ({instD, pcD, pc, stallCnt} !== {memWord(32'h4), 32'h4, 32'h8, 32'd3}) begin errors++;
          $display("[TB] FAIL stall_third: got D=%h pcD=%h pc=%h cnt=%0d", instD, pcD, pc, stallCnt); end
        stall = 1'b0;
      end
      if (k == 7) begin
        checks++; if ({instD, instE, pc} !== {memWord(32'h8), memWord(32'h4), 32'hC}) begin errors++;
          $display("[TB] FAIL stall_release: got D=%h E=%h pc=%h", instD, instE, pc); end
      end
      if (k >= 5 && expQ.size() > 0) begin
        expW = expQ.pop_front();
        checks++; if (instW !== expW) begin errors++; $display("[TB] FAIL stall_W_c%0d: got %h expected %h", k, instW, expW); end
      end
      if (k == 9) begin
        checks++; if (retireCnt !== 32'd1) begin errors++; $display("[TB] FAIL stall_retire: got %0d expected 1", retireCnt); end
      end
    end
  endtask

  task automatic test_flush();
    doReset();
    tick(); tick(); tick();
    flush = 1'b1; target = 32'h100;
    tick();
    checks++; if ({pc, instD, instE, instF} !== {32'h100, NOPW, NOPW, NOPW}) begin errors++;
      $display("[TB] FAIL flush_redirect: got pc=%h D=%h E=%h F=%h", pc, instD, instE, instF); end
    checks++; if ({instM, flushCnt} !== {memWord(32'h0), 32'd1}) begin errors++;
      $display("[TB] FAIL flush_M_cnt: got M=%h cnt=%0d expected M=%h cnt=1", instM, flushCnt, memWord(32'h0)); end
    flush = 1'b0;
    tick();
    checks++; if ({pc, instF} !== {32'h100, memWord(32'h100)}) begin errors++;
      $display("[TB] FAIL flush_refetch: got pc=%h F=%h expected pc=100 F=%h", pc, instF, memWord(32'h100)); end
    tick();
    checks++; if ({pc, instD, pcD} !== {32'h104, memWord(32'h100), 32'h100}) begin errors++;
      $display("[TB] FAIL flush_resume: got pc=%h D=%h pcD=%h", pc, instD, pcD); end
    flush = 1'b1; stall = 1'b1; target = 32'h202;
    tick();
    checks++; if ({pc, instD, stallCnt, flushCnt} !== {32'h202, NOPW, 32'd0, 32'd2}) begin errors++;
      $display("[TB] FAIL flush_and_stall: got pc=%h D=%h stall=%0d flush=%0d", pc, instD, stallCnt, flushCnt); end
    flush = 1'b0;
    tick(); tick();
    checks++; if (stallCnt !== 32'd2) begin errors++; $display("[TB] FAIL midstall_cnt: got %0d expected 2", stallCnt); end
    rst = 1'b1; flush = 1'b1; target = 32'h300;
    tick();
    checkResetState("midstall_reset");
    rst = 1'b0; stall = 1'b0; flush = 1'b0;
  endtask

  task automatic test_wrap();
    doReset();
    flush = 1'b1; target = 32'hFFFF_FFFC;
    tick();
    checks++; if (pc !== 32'hFFFF_FFFC) begin errors++; $display("[TB] FAIL wrap_target: got %h expected %h", pc, 32'hFFFF_FFFC); end
    flush = 1'b0;
    tick(); tick();
    checks++; if ({pc, pcD} !== {32'h0, 32'hFFFF_FFFC}) begin errors++;
      $display("[TB] FAIL wrap_pc: got pc=%h pcD=%h expected pc=0 pcD=fffffffc", pc, pcD); end
  endtask

  task automatic test_saturate();
    doReset();
    checks++; if (satStallCnt !== 32'hFFFF_FFFE) begin errors++; $display("[TB] FAIL sat_preset: got %h expected %h", satStallCnt, 32'hFFFF_FFFE); end
    stall = 1'b1;
    tick();
    checks++; if (satStallCnt !== MAXW) begin errors++; $display("[TB] FAIL sat_stall_reach: got %h expected %h", satStallCnt, MAXW); end
    tick();
    checks++; if (satStallCnt !== MAXW) begin errors++; $display("[TB] FAIL sat_stall_hold: got %h expected %h", satStallCnt, MAXW); end
    stall = 1'b0; flush = 1'b1; target = 32'h0;
    tick(); tick();
    checks++; if (satFlushCnt !== MAXW) begin errors++; $display("[TB] FAIL sat_flush: got %h expected %h", satFlushCnt, MAXW); end
    flush = 1'b0;
    for (int k = 0; k < 8; k++) tick();
    checks++; if (satRetireCnt !== MAXW) begin errors++; $display("[TB] FAIL sat_retire: got %h expected %h", satRetireCnt, MAXW); end
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    rst = 1'b1; stall = 1'b0; flush = 1'b0; target = 32'h0;
    test_reset();
    test_straight_line();
    test_stall();
    test_flush();
    test_wrap();
    test_saturate();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
